// File: rtl/la_aoi_pkg.sv
// Shared constants and the per-lane AND-OR(-INVERT) evaluation for la_aoi_pipe.
package la_aoi_pkg;

  localparam int unsigned LA_AOI_MAX_STAGES = 4;
  // Widest AND/OR group a single lane supports; callers pad unused bits.
  localparam int unsigned LA_AOI_MAX_IN = 64;

  // Callers pad unused a bits with 1 and unused b bits with 0, so padding never changes the result.
  function automatic logic la_aoi_lane(
    input logic [LA_AOI_MAX_IN-1:0] a_slice,
    input logic [LA_AOI_MAX_IN-1:0] b_slice,
    input logic                     inv
  );
    logic f;
    f = (&a_slice) | (|b_slice);
    return inv ? ~f : f;
  endfunction

endpackage

// File: rtl/la_pipe_stage.sv
// One valid/ready register slice: loads when empty or when downstream is ready.
module la_pipe_stage
  import la_aoi_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_rdy,
  output logic          o_en_c,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_v;
  logic [DW-1:0] r_d;

  // An empty slice always accepts, so bubbles collapse.
  assign o_en_c = ~r_v | i_rdy;

  // Valid/data register; reset clears both so z is never X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (o_en_c) begin
      r_v <= i_valid;
      r_d <= i_data;
    end
  end

  assign o_valid = r_v;
  assign o_data  = r_d;

endmodule

// File: rtl/la_aoi_pipe.sv
// Pipelined WIDTH-lane And-Or-Invert gate with valid/ready backpressure.
module la_aoi_pipe
  import la_aoi_pkg::*;
#(
  parameter     PROP   = "DEFAULT",
  parameter int WIDTH  = 8,
  parameter int AN     = 3,
  parameter int BN     = 1,
  parameter int STAGES = 1,
  parameter int INV    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH*AN-1:0] a,
  input  logic [WIDTH*BN-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    z
);

  // Elaboration-time parameter checks.
  if (STAGES < 0 || STAGES > int'(LA_AOI_MAX_STAGES)) begin : g_err_stages
    $error("la_aoi_pipe %s: STAGES=%0d outside 0..%0d", PROP, STAGES, LA_AOI_MAX_STAGES);
  end
  if (WIDTH < 1 || AN < 1 || BN < 1) begin : g_err_dims
    $error("la_aoi_pipe %s: WIDTH, AN and BN must be >= 1", PROP);
  end
  if (AN > int'(LA_AOI_MAX_IN) || BN > int'(LA_AOI_MAX_IN)) begin : g_err_fanin
    $error("la_aoi_pipe %s: AN/BN exceed %0d", PROP, LA_AOI_MAX_IN);
  end

  logic [WIDTH-1:0] w_f;

  // Lane evaluation on operands; only results get registered.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [LA_AOI_MAX_IN-1:0] w_a_pad;
    logic [LA_AOI_MAX_IN-1:0] w_b_pad;

    // Pad AND group with ones and OR group with zeros.
    always_comb begin
      w_a_pad         = '1;
      w_b_pad         = '0;
      w_a_pad[AN-1:0] = a[i*AN +: AN];
      w_b_pad[BN-1:0] = b[i*BN +: BN];
    end

    assign w_f[i] = la_aoi_lane(w_a_pad, w_b_pad, 1'(INV));
  end

  if (STAGES == 0) begin : g_comb
    // Pure combinational path; clk and rst have no effect.
    logic w_unused;
    assign w_unused  = clk ^ rst;
    assign z         = w_f;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else begin : g_pipe
    logic             w_v   [STAGES];
    logic [WIDTH-1:0] w_d   [STAGES];
    logic             w_en  [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;
      logic             w_dn_rdy;

      if (s == 0) begin : g_head
        assign w_up_valid = in_valid;
        assign w_up_data  = w_f;
      end else begin : g_mid
        assign w_up_valid = w_v[s-1];
        assign w_up_data  = w_d[s-1];
      end

      if (s == STAGES - 1) begin : g_tail
        assign w_dn_rdy = out_ready;
      end else begin : g_inner
        assign w_dn_rdy = w_en[s+1];
      end

      la_pipe_stage #(
        .DW (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_up_valid),
        .i_data  (w_up_data),
        .i_rdy   (w_dn_rdy),
        .o_en_c  (w_en[s]),
        .o_valid (w_v[s]),
        .o_data  (w_d[s])
      );
    end

    // No beat is taken while reset is asserted.
    assign in_ready  = w_en[0] & ~rst;
    assign out_valid = w_v[STAGES-1];
    assign z         = w_d[STAGES-1];
  end

endmodule

// File: tb/tb_la_aoi_pipe.sv
// Directed-vector bench for la_aoi_pipe across combinational, 2-stage and AO configurations.
module tb_la_aoi_pipe;

  logic clk;
  logic rst;

  // Combinational aoi31 instance.
  logic       v0, r0, ov0, or0;
  logic [2:0] a0;
  logic [0:0] b0;
  logic [0:0] z0;

  // Two-stage, 2-lane instance.
  logic       v2, r2, ov2, or2;
  logic [5:0] a2;
  logic [3:0] b2;
  logic [1:0] z2;

  // One-stage AO instance.
  logic       v4, r4, ov4, or4;
  logic [7:0] a4;
  logic [3:0] b4;
  logic [3:0] z4;

  int n_tests;
  int n_fail;

  la_aoi_pipe #(.WIDTH(1), .AN(3), .BN(1), .STAGES(0), .INV(1)) u_c0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .z(z0));

  la_aoi_pipe #(.WIDTH(2), .AN(3), .BN(2), .STAGES(2), .INV(1)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .z(z2));

  la_aoi_pipe #(.WIDTH(4), .AN(2), .BN(1), .STAGES(1), .INV(0)) u_ao (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .z(z4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string name, input logic got_v, input logic exp_v,
                      input logic [1:0] got_z, input logic [1:0] exp_z, input logic check_z);
    n_tests++;
    if (got_v !== exp_v || (check_z && got_z !== exp_z)) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b z=%b, expected out_valid=%b z=%b", name, got_v, got_z, exp_v, exp_z);
    end
  endtask

  task automatic chk_rdy(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v0 = 0; or0 = 1; a0 = '0; b0 = '0;
    v2 = 0; or2 = 1; a2 = '0; b2 = '0;
    v4 = 0; or4 = 1; a4 = '0; b4 = '0;
    step();
    step();
    chk2("reset_p2_out", ov2, 1'b0, z2, 2'b00, 1'b1);
    chk_rdy("reset_p2_rdy_low", r2, 1'b0);
    n_tests++;
    if (ov4 !== 1'b0 || z4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ao_out: out_valid=%b z=%b, expected 0 0000", ov4, z4);
    end
    rst = 1'b0;
    #1;
    chk_rdy("reset_p2_rdy_after", r2, 1'b1);
  endtask

  task automatic test_truth_table();
    logic       exp;
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      a0  = idx[3:1];
      b0  = idx[0:0];
      v0  = idx[0];
      or0 = idx[1];
      exp = (a0 == 3'b111 || b0 == 1'b1) ? 1'b0 : 1'b1;
      #1;
      n_tests++;
      if (z0 !== exp || ov0 !== v0 || r0 !== or0) begin
        n_fail++;
        $display("FAIL truth a=%b b=%b: z=%b ov=%b rdy=%b, expected z=%b ov=%b rdy=%b",
                 a0, b0, z0, ov0, r0, exp, v0, or0);
      end
    end
  endtask

  task automatic test_latency();
    logic [5:0] av [4];
    logic [1:0] ez [4];
    av[0] = 6'b111_011; ez[0] = 2'b01;
    av[1] = 6'b111_111; ez[1] = 2'b00;
    av[2] = 6'b000_000; ez[2] = 2'b11;
    av[3] = 6'b000_111; ez[3] = 2'b10;
    or2 = 1'b1;
    b2  = 4'b00_00;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        v2 = 1'b1;
        a2 = av[c];
      end else begin
        v2 = 1'b0;
        a2 = 6'b101_010;
      end
      step();
      if (c >= 1 && c <= 4)
        chk2($sformatf("latency_out%0d", c), ov2, 1'b1, z2, ez[c-1], 1'b1);
      else
        chk2($sformatf("latency_idle%0d", c), ov2, 1'b0, z2, 2'b00, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    or2 = 1'b0;
    b2  = 4'b00_00;
    v2 = 1'b1; a2 = 6'b111_111;
    #1;
    chk_rdy("bp_rdy_beat1", r2, 1'b1);
    step();
    v2 = 1'b1; a2 = 6'b000_000;
    #1;
    chk_rdy("bp_rdy_beat2", r2, 1'b1);
    step();
    chk2("bp_head_beat1", ov2, 1'b1, z2, 2'b00, 1'b1);
    v2 = 1'b1; a2 = 6'b111_000;
    #1;
    chk_rdy("bp_rdy_full", r2, 1'b0);
    step();
    chk2("bp_hold_beat1", ov2, 1'b1, z2, 2'b00, 1'b1);
    or2 = 1'b1;
    #1;
    chk_rdy("bp_rdy_release", r2, 1'b1);
    step();
    v2 = 1'b0;
    chk2("bp_out_beat2", ov2, 1'b1, z2, 2'b11, 1'b1);
    step();
    chk2("bp_out_beat3", ov2, 1'b1, z2, 2'b01, 1'b1);
    step();
    chk2("bp_drained", ov2, 1'b0, z2, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back_full();
    or2 = 1'b0;
    v2 = 1'b1; a2 = 6'b000_000; b2 = 4'b00_00;
    step();
    v2 = 1'b1; a2 = 6'b111_000; b2 = 4'b00_00;
    step();
    chk2("sim_full_q1", ov2, 1'b1, z2, 2'b11, 1'b1);
    or2 = 1'b1;
    v2 = 1'b1; a2 = 6'b000_000; b2 = 4'b00_01;
    #1;
    chk_rdy("sim_rdy_full_pass", r2, 1'b1);
    step();
    chk2("sim_out_q2", ov2, 1'b1, z2, 2'b01, 1'b1);
    or2 = 1'b0;
    v2  = 1'b0;
    #1;
    chk_rdy("sim_still_full", r2, 1'b0);
    step();
    chk2("sim_hold_q2", ov2, 1'b1, z2, 2'b01, 1'b1);
    or2 = 1'b1;
    step();
    chk2("sim_out_q3", ov2, 1'b1, z2, 2'b10, 1'b1);
    step();
    chk2("sim_drained", ov2, 1'b0, z2, 2'b00, 1'b0);
    b2 = 4'b00_00;
  endtask

  task automatic test_reset_midstream();
    or2 = 1'b0;
    v2 = 1'b1; a2 = 6'b000_000;
    step();
    v2 = 1'b1; a2 = 6'b111_000;
    step();
    chk2("rst_mid_loaded", ov2, 1'b1, z2, 2'b11, 1'b1);
    rst = 1'b1;
    v2  = 1'b1; a2 = 6'b000_111;
    or2 = 1'b1;
    #1;
    chk_rdy("rst_mid_rdy_low", r2, 1'b0);
    step();
    chk2("rst_mid_cleared", ov2, 1'b0, z2, 2'b00, 1'b1);
    rst = 1'b0;
    v2  = 1'b0;
    #1;
    chk_rdy("rst_mid_rdy_after", r2, 1'b1);
    step();
    chk2("rst_mid_no_old1", ov2, 1'b0, z2, 2'b00, 1'b0);
    step();
    chk2("rst_mid_no_old2", ov2, 1'b0, z2, 2'b00, 1'b0);
  endtask

  task automatic test_ao_inv0();
    or4 = 1'b1;
    v4 = 1'b1; a4 = 8'b11_10_01_00; b4 = 4'b0010;
    step();
    v4 = 1'b0; a4 = 8'b11_11_11_11; b4 = 4'b1111;
    n_tests++;
    if (ov4 !== 1'b1 || z4 !== 4'b1010) begin
      n_fail++;
      $display("FAIL ao_result: out_valid=%b z=%b, expected 1 1010", ov4, z4);
    end
    step();
    n_tests++;
    if (ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL ao_idle: out_valid=%b, expected 0", ov4);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_truth_table();
    test_latency();
    test_backpressure();
    test_back_to_back_full();
    test_reset_midstream();
    test_ao_inv0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
